// File: rtl/mul_pkg.sv
// Shared definitions for the multiply sequencer.
//   - op encodings driven by the decoder (MUL, MLA, UMULL, SMULL)
//   - state encoding for the sequencing FSM
package mul_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StIter = 2'b01,
        StFin  = 2'b10,
        StDone = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: operand capture, one multiplier bit per step,
// final sign fix / accumulate, and the registers holding the last completed result.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   load_i                 capture op/operands, clear the product
//   step_i                 one shift-add iteration
//   finish_i               apply sign fix / accumulate and commit the result
//   op_i, src_a_i, src_b_i, acc_i   operation and operands (sampled on load_i)
//   res_lo_o, res_hi_o     last completed result
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             finish_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] res_lo_o,
    output logic [WIDTH-1:0] res_hi_o
);

    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    // lo_q starts out holding the multiplier; product bits shift in from the top
    // as multiplier bits are consumed from the bottom.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_lo, fin_hi;

    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;

        // Signed operands become magnitudes; -(2^(W-1)) wraps to 2^(W-1), which
        // is exactly right as an unsigned magnitude.
        mag_a = src_a_i;
        mag_b = src_b_i;
        if (op_i == OP_SMULL) begin
            if (src_a_i[WIDTH-1]) mag_a = -src_a_i;
            if (src_b_i[WIDTH-1]) mag_b = -src_b_i;
        end

        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

        prod = {hi_q, lo_q};
        if (op_q == OP_SMULL && neg_q) prod = -prod;
        fin_lo = prod[WIDTH-1:0];
        fin_hi = prod[2*WIDTH-1:WIDTH];
        if (op_q == OP_MLA) fin_lo = fin_lo + acc_q;
        if (op_q == OP_MUL || op_q == OP_MLA) fin_hi = '0;

        if (load_i) begin
            op_d    = op_i;
            neg_d   = (op_i == OP_SMULL) & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
            mcand_d = mag_a;
            acc_d   = acc_i;
            hi_d    = '0;
            lo_d    = mag_b;
        end else if (step_i) begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end

        if (finish_i) begin
            res_lo_d = fin_lo;
            res_hi_d = fin_hi;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign res_lo_o = res_lo_q;
    assign res_hi_o = res_hi_q;

endmodule

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiply sequencer (MUL, MLA, UMULL, SMULL) for the multicycle core.
// Started from Execute, it holds the main FSM through Stall until the product is ready.
// Ports:
//   clk, reset            clock, async active-low reset
//   start, cancel         request a multiply / synchronous abort
//   op                    00 MUL, 01 MLA, 10 UMULL, 11 SMULL
//   SrcA, SrcB, Acc       multiplicand, multiplier, accumulate operand
//   busy, done, Stall     in progress / one-cycle result pulse / hold main FSM
//   ResultLo, ResultHi    product words (zero while an operation is running)
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] Acc,
    output logic             busy,
    output logic             done,
    output logic             Stall,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi
);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             load, step, finish;
    logic [WIDTH-1:0] res_lo, res_hi;

    assign accept = (state_q == StIdle || state_q == StDone) && start && !cancel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StIter;
                    cnt_d   = CNT_W'(WIDTH);
                    load    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StIter: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = StFin;
                end
            end
            StFin: begin
                // A cancel here drops the result; the previous one stays committed.
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    finish  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i    (clk),
        .rst_ni   (reset),
        .load_i   (load),
        .step_i   (step),
        .finish_i (finish),
        .op_i     (op),
        .src_a_i  (SrcA),
        .src_b_i  (SrcB),
        .acc_i    (Acc),
        .res_lo_o (res_lo),
        .res_hi_o (res_hi)
    );

    assign busy  = (state_q == StIter) || (state_q == StFin);
    assign done  = (state_q == StDone);
    assign Stall = busy || accept;

    // An accepted start clears the visible result until the new one is committed;
    // a cancel therefore falls back to the last completed value.
    assign ResultLo = busy ? '0 : res_lo;
    assign ResultHi = busy ? '0 : res_hi;

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
    import mul_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [1:0]  op;
    logic [31:0] SrcA, SrcB, Acc;
    logic        busy, done, Stall;
    logic [31:0] ResultLo, ResultHi;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    mul_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cancel   (cancel),
        .op       (op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Acc      (Acc),
        .busy     (busy),
        .done     (done),
        .Stall    (Stall),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got result %h, expected no done at %0t",
                         {ResultHi, ResultLo}, $time);
            end else begin
                check("result", {ResultHi, ResultLo}, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
        op = o; SrcA = a; SrcB = b; Acc = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs to prove operands were captured.
        op = ~o; SrcA = 32'hA5A5_5A5A; SrcB = 32'h1234_5678; Acc = 32'hDEAD_BEEF;
    endtask

    // Returns at the negedge of the done cycle; n = rising edges waited.
    task automatic wait_done(input string name, output int n, output int nb);
        n = 0;
        nb = 0;
        while (n < 60) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done, expected done within 60 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [63:0] exp);
        int n, nb;
        exp_q.push_back(exp);
        start_op(o, a, b, c);
        wait_done(name, n, nb);
        check({name, "_latency"}, 64'(n + 1), 64'd34);
        check({name, "_busy_cycles"}, 64'(nb), 64'd33);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, nb;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = OP_MUL;
        SrcA = '0; SrcB = '0; Acc = '0;
        #23;
        check("reset_outputs", {59'b0, busy, done, Stall, 2'b0}, 64'd0);
        check("reset_result", {ResultHi, ResultLo}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Stall is asserted combinationally in the accepting cycle.
        op = OP_MUL; SrcA = 32'd7; SrcB = 32'd6; start = 1'b1; #1;
        check("stall_on_accept", {62'b0, Stall, busy}, 64'b10);
        start = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'd0, 64'd42);
        run_op("umull_max", OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
               64'hFFFF_FFFE_0000_0001);
        run_op("smull_m1_min", OP_SMULL, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
               64'h0000_0000_8000_0000);
        run_op("smull_min_min", OP_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0,
               64'h4000_0000_0000_0000);
        run_op("smull_m3_7", OP_SMULL, 32'hFFFF_FFFD, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mla_wrap", OP_MLA, 32'd3, 32'd4, 32'hFFFF_FFFF, 64'h0000_0000_0000_000B);
        run_op("mul_trunc", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 64'd0);
        run_op("umull_2p32", OP_UMULL, 32'h0001_0000, 32'h0001_0000, 32'd0,
               64'h0000_0001_0000_0000);

        // start while busy is ignored.
        exp_q.push_back(64'h0000_0000_0000_0063);
        start_op(OP_MUL, 32'd9, 32'd11, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        op = OP_UMULL; SrcA = 32'd2; SrcB = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("start_while_busy", n, nb);
        check("start_while_busy_latency", 64'(n + 6), 64'd34);
        @(posedge clk); #1;

        // cancel at ITER cycle 10: back to IDLE, previous result visible, no done.
        start_op(OP_UMULL, 32'd5, 32'd5, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        check("cleared_while_busy", {ResultHi, ResultLo}, 64'd0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_idle", {61'b0, busy, done, Stall}, 64'd0);
        check("cancel_revert", {ResultHi, ResultLo}, 64'h0000_0000_0000_0063);
        repeat (40) begin @(posedge clk); #1; end

        // cancel + start on the same edge: start dropped.
        op = OP_MUL; SrcA = 32'd2; SrcB = 32'd2; start = 1'b1; cancel = 1'b1; #1;
        check("cancel_start_stall", {63'b0, Stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_idle", {63'b0, busy}, 64'd0);
        repeat (40) begin @(posedge clk); #1; end

        // Reset mid-ITER aborts immediately to reset values.
        start_op(OP_MLA, 32'd3, 32'd3, 32'd1);
        repeat (7) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("reset_mid_flags", {61'b0, busy, done, Stall}, 64'd0);
        check("reset_mid_result", {ResultHi, ResultLo}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        repeat (40) begin @(posedge clk); #1; end

        // Back-to-back: start accepted in the DONE cycle.
        exp_q.push_back(64'h4000_0000_0000_0000);
        start_op(OP_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0);
        wait_done("b2b_first", n, nb);
        exp_q.push_back(64'h0000_0000_0000_000B);
        op = OP_MLA; SrcA = 32'd3; SrcB = 32'd4; Acc = 32'hFFFF_FFFF; start = 1'b1; #1;
        check("b2b_stall", {63'b0, Stall}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0; SrcA = '0; SrcB = '0; Acc = '0;
        wait_done("b2b_second", n, nb);
        check("b2b_spacing", 64'(n + 1), 64'd34);
        repeat (3) begin @(posedge clk); #1; end

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion by 200000");
        $fatal(1, "watchdog");
    end

endmodule
